// File: rtl/hazard_mc.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding, load-use/branch stalls,
// multi-cycle divide stall FSM, data-memory freeze, exception flush and a stall counter.
`timescale 1ns/1ps
module hazard_mc #(
    parameter int REG_AW     = 5,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              memtoregE,
    input  logic              memtoregM,
    input  logic              branchD,
    input  logic              div_startE,
    input  logic              dmem_stall,
    input  logic              except_valid,
    input  logic              cnt_clr,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              forwardAD,
    output logic              forwardBD,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              div_busy,
    output logic              div_done,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    // BUSY lasts DIV_CYCLES-1 cycles; together with the start cycle that is DIV_CYCLES stalls.
    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 2);

    div_state_t        state_reg, state_next;
    logic [7:0]        count_reg, count_next;
    logic [CNT_W-1:0]  stall_cnt_reg;

    logic [REG_AW-1:0] src_e [2];
    logic [REG_AW-1:0] src_d [2];
    logic [1:0]        fwd_e [2];
    logic              fwd_d [2];

    assign src_e[0] = rsE;
    assign src_e[1] = rtE;
    assign src_d[0] = rsD;
    assign src_d[1] = rtD;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd_e[gi] = 2'b00;
                if (src_e[gi] != '0 && src_e[gi] == writeregM && regwriteM)
                    fwd_e[gi] = 2'b10;
                else if (src_e[gi] != '0 && src_e[gi] == writeregW && regwriteW)
                    fwd_e[gi] = 2'b01;
            end
            assign fwd_d[gi] = (src_d[gi] != '0) && (src_d[gi] == writeregM) && regwriteM;
        end
    endgenerate

    assign forwardAE = fwd_e[0];
    assign forwardBE = fwd_e[1];
    assign forwardAD = fwd_d[0];
    assign forwardBD = fwd_d[1];

    logic e_hit, m_hit, lwstall, brstall, busy_raw;

    assign e_hit    = (writeregE != '0) && (writeregE == rsD || writeregE == rtD);
    assign m_hit    = (writeregM != '0) && (writeregM == rsD || writeregM == rtD);
    assign lwstall  = memtoregE && e_hit;
    assign brstall  = branchD && ((regwriteE && e_hit) || (memtoregM && m_hit));
    assign busy_raw = (state_reg == IDLE && div_startE) || (state_reg == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        flushW = 1'b0;

        if (except_valid) begin
            state_next = IDLE;
            count_next = '0;
        end else if (!dmem_stall) begin
            case (state_reg)
                IDLE: if (div_startE) begin
                    state_next = BUSY;
                    count_next = DIV_LOAD;
                end
                BUSY: if (count_reg == '0) state_next = DONE;
                      else count_next = count_reg - 8'd1;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end

        // Exactly one priority row drives the pipeline controls; reset masks them all.
        if (!rst) begin
            if (except_valid) begin
                flushD = 1'b1;
                flushE = 1'b1;
                flushM = 1'b1;
                flushW = 1'b1;
            end else if (dmem_stall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (busy_raw) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end else if (lwstall || brstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    assign div_busy = !rst && busy_raw;
    assign div_done = !rst && (state_reg == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_reg <= '0;
        else if (cnt_clr)
            stall_cnt_reg <= '0;
        else if (stallF && !(&stall_cnt_reg))
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end

    assign stall_cnt = stall_cnt_reg;
endmodule

// File: doc/hazard_mc.md
Name: hazard_mc

Overview:
Next-generation pipeline hazard controller for the 5-stage MIPS core (F/D/E/M/W). It keeps the existing combinational forwarding and load-use/branch stall detection, with register-0 handling made consistent across all checks. It adds:
- a multi-cycle divide stall FSM;
- data-memory wait freezing;
- exception flush with a defined priority order;
- a saturating stall-cycle performance counter.

It sits beside the datapath and drives every pipeline-register enable and clear.

Parameters:
REG_AW, 5, register-index width (2**REG_AW architectural registers; index 0 is hardwired zero)
DIV_CYCLES, 32, total front-end stall cycles per divide; legal range 2..255
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
rsD, rtD  in  REG_AW  source registers in D
rsE, rtE  in  REG_AW  source registers in E
writeregE, writeregM, writeregW  in  REG_AW  destination register in E/M/W
regwriteE, regwriteM, regwriteW  in  1  stage writes register file
memtoregE, memtoregM  in  1  stage holds a load
branchD  in  1  branch/compare in D
div_startE  in  1  divide instruction in E
dmem_stall  in  1  data memory not ready
except_valid  in  1  exception raised by instruction in M
cnt_clr  in  1  synchronous clear of stall_cnt
forwardAE, forwardBE  out  2  E operand select: 10=M, 01=W, 00=regfile
forwardAD, forwardBD  out  1  D compare operand forwarded from M
stallF, stallD, stallE, stallM  out  1  hold stage register
flushD, flushE, flushM, flushW  out  1  clear stage register (insert bubble)
div_busy  out  1  divide in progress
div_done  out  1  one-cycle pulse: divide result valid in E
stall_cnt  out  CNT_W  cycles with stallF=1

Behaviour:
Forwarding (combinational):
- forwardXE = 10 if src!=0 & src==writeregM & regwriteM; else 01 if src!=0 & src==writeregW & regwriteW; else 00. M has priority over W.
- forwardXD = src!=0 & src==writeregM & regwriteM.

Hazard terms (combinational; a source of 0 never matches):
- lwstall = memtoregE & writeregE!=0 & (writeregE==rsD | writeregE==rtD).
- brstall = branchD & ((regwriteE & writeregE!=0 & match(writeregE)) | (memtoregM & writeregM!=0 & match(writeregM))).

Divide FSM (states IDLE, BUSY, DONE; counter 8 bits):
- IDLE -> BUSY when div_startE. Counter loads DIV_CYCLES-2.
- BUSY: counter decrements each cycle; at counter==0 -> DONE.
- DONE -> IDLE after one cycle.
- div_busy = (IDLE & div_startE) | BUSY, so the start cycle is already stalled. Stalled cycles = DIV_CYCLES exactly.
- div_done = (state==DONE). The DONE cycle is not stalled by the FSM.
- While dmem_stall=1 the FSM and counter hold (no transitions).
- except_valid=1 forces IDLE next cycle from any state, counter 0.

Control priority (highest first; exactly one row applies):
1. except_valid: flushD=flushE=flushM=flushW=1; all stalls 0 so F loads the redirect PC.
2. dmem_stall: stallF=stallD=stallE=stallM=1; flushW=1; all other outputs 0.
3. div_busy: stallF=stallD=stallE=1; flushM=1.
4. lwstall|brstall: stallF=stallD=1; flushE=1.
5. Otherwise all stall/flush outputs 0.

Other rules:
- A stage never sees stall and flush both high.
- stall_cnt increments on each clk where stallF=1, saturating at all-ones.
- cnt_clr has priority over increment: the register loads 0 that edge.

Reset (asynchronous, rst=1):
- FSM to IDLE, counter 0, stall_cnt 0.
- All stall/flush outputs, div_busy and div_done forced 0.
- Forwarding outputs stay combinational.
- First active edge after reset release behaves as IDLE.

Test Plan:
- Forwarding: rsE=3, writeregM=3, regwriteM=1, writeregW=3, regwriteW=1 -> forwardAE=10. Repeat with rsE=0 -> 00. Repeat with regwriteM=0 -> 01.
- Load-use: memtoregE=1, writeregE=5, rtD=5 -> stallF=stallD=flushE=1 for one cycle, stall_cnt +1. Repeat with writeregE=0 -> no stall.
- Divide, DIV_CYCLES=4: div_startE pulse -> stallF/D/E=1 and flushM=1 for exactly 4 cycles, div_done=1 on cycle 5, then IDLE.
- Divide with dmem_stall high 3 cycles mid-BUSY -> stallM=1 and flushW=1 during those cycles, divide stall total 7 cycles. Assert except_valid during BUSY -> all flushes 1 that cycle, IDLE next cycle, no div_done.
- Simultaneous except_valid, dmem_stall and lwstall -> only the exception row drives outputs (flushD..W=1, stalls 0).
- Assert rst mid-BUSY -> outputs 0 immediately. After release, no stall until a new div_startE. stall_cnt saturates at 2**CNT_W-1 (run with CNT_W=4), then cnt_clr -> 0.
